// File: rtl/lu_pkg.sv
// lu_pkg: operation codes and flag bundle shared by the logic unit pipeline.
package lu_pkg;
    typedef logic [2:0] lu_op_t;
    localparam lu_op_t OP_AND  = 3'd0;
    localparam lu_op_t OP_OR   = 3'd1;
    localparam lu_op_t OP_XOR  = 3'd2;
    localparam lu_op_t OP_NOT  = 3'd3;
    localparam lu_op_t OP_NAND = 3'd4;
    localparam lu_op_t OP_NOR  = 3'd5;
    localparam lu_op_t OP_XNOR = 3'd6;
    localparam lu_op_t OP_PASS = 3'd7;
    typedef struct packed {
        logic zero;
        logic par;
        logic ones;
    } lu_flags_t;
endpackage

// File: rtl/lu_core.sv
// lu_core: combinational bitwise operation with zero/parity/all-ones flags.
module lu_core
    import lu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] y,
    input  lu_op_t           op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             par,
    output logic             ones
);
    always_comb begin
        result = y;
        case (op)
            OP_AND:  result = a & y;
            OP_OR:   result = a | y;
            OP_XOR:  result = a ^ y;
            OP_NOT:  result = ~a;
            OP_NAND: result = ~(a & y);
            OP_NOR:  result = ~(a | y);
            OP_XNOR: result = ~(a ^ y);
            default: result = y;
        endcase
    end
    assign zero = ~|result;
    assign par  = ^result;
    assign ones = &result;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered logic unit with accumulator chaining and a
// single-entry valid/ready output stage.
module logic_unit_pipe
    import lu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_wr,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             zero,
    output logic             par,
    output logic             ones,
    output logic [WIDTH-1:0] acc,
    output logic [CNTW-1:0]  count
);
    logic [WIDTH-1:0] a, res, f_q, f_d, acc_q, acc_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             out_valid_q, out_valid_d, in_xfer;
    lu_flags_t        flg, flags_q, flags_d;

    assign a = acc_sel ? acc_q : x;

    lu_core #(.WIDTH(WIDTH)) u_core (
        .a      (a),
        .y      (y),
        .op     (lu_op_t'(op)),
        .result (res),
        .zero   (flg.zero),
        .par    (flg.par),
        .ones   (flg.ones)
    );

    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;

    // Clear beats a concurrent write; the transfer itself already used the old acc.
    always_comb begin
        f_d         = in_xfer ? res : f_q;
        flags_d     = in_xfer ? flg : flags_q;
        out_valid_d = in_xfer || (out_valid_q && !out_ready);
        count_d     = count_q + CNTW'(in_xfer);
        acc_d       = acc_clr ? '0 : (in_xfer && acc_wr) ? res : acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q         <= '0;
            flags_q     <= '{zero: 1'b1, par: 1'b0, ones: 1'b0};
            out_valid_q <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
        end else begin
            f_q         <= f_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign zero      = flags_q.zero;
    assign par       = flags_q.par;
    assign ones      = flags_q.ones;
    assign acc       = acc_q;
    assign count     = count_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and random stimulus against a reference model,
// with a scoreboard monitor checking every presented result.
module tb_logic_unit_pipe;
    logic       clk = 0, rst_n = 0, in_valid = 0, acc_sel = 0, acc_wr = 0, acc_clr = 0, out_ready = 1;
    logic [7:0] x = 0, y = 0;
    logic [2:0] op = 0;
    logic       in_ready, out_valid, zero, par, ones;
    logic [7:0] f, acc, count;
    logic       in_ready2, out_valid2, zero2, par2, ones2;
    logic [7:0] f2, acc2;
    logic [1:0] count2;

    logic_unit_pipe #(.WIDTH(8), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .op(op), .acc_sel(acc_sel), .acc_wr(acc_wr), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero), .par(par),
        .ones(ones), .acc(acc), .count(count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNTW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .x(x), .y(y), .op(op), .acc_sel(acc_sel), .acc_wr(acc_wr), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .f(f2), .zero(zero2), .par(par2),
        .ones(ones2), .acc(acc2), .count(count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] f;
        logic       z, p, o;
    } exp_t;
    exp_t q[$];

    int         errors = 0, checks = 0, ref_count = 0, bp = 0, tries = 0, c0;
    logic [7:0] ref_acc = 0;
    bit         ref_ov = 0, rnd = 0, accepted = 0;

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: check state before the edge, advance the model, then drive out_ready.
    task automatic step();
        bit         rdy;
        logic [7:0] r, nacc;
        @(negedge clk);
        rdy = rst_n && (!ref_ov || out_ready);
        chk("in_ready", in_ready, rdy);
        chk("acc", acc, ref_acc);
        chk("count", count, ref_count % 256);
        chk("count_w2", count2, ref_count % 4);
        accepted = in_valid && rdy;
        if (!rst_n) begin
            ref_ov = 0; ref_acc = 0; ref_count = 0; q.delete();
        end else begin
            nacc = ref_acc;
            if (accepted) begin
                r = model(acc_sel ? ref_acc : x, y, op);
                q.push_back('{r, r == 8'h00, ^r, r == 8'hFF});
                ref_count++;
                ref_ov = 1;
                if (acc_wr) nacc = r;
            end else if (out_ready) ref_ov = 0;
            ref_acc = acc_clr ? 8'h00 : nacc;
        end
        @(posedge clk); #1;
        out_ready = bp > 0 ? 1'b0 : rnd ? ($urandom % 4 != 0) : 1'b1;
        if (bp > 0) bp--;
    endtask

    task automatic send(input logic [7:0] xi, input logic [7:0] yi, input logic [2:0] oi,
                        input bit s, input bit w, input bit c);
        x = xi; y = yi; op = oi; acc_sel = s; acc_wr = w; acc_clr = c; in_valid = 1;
        accepted = 0;
        tries = 0;
        while (!accepted && tries < 20) begin
            step();
            tries++;
        end
        if (!accepted) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no transfer expected one within 20 cycles");
        end
        in_valid = 0; acc_wr = 0; acc_clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0;
        step();
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got out_valid=1 expected no pending result");
            end else begin
                chk("sb_f", f, q[0].f);
                chk("sb_zero", zero, q[0].z);
                chk("sb_par", par, q[0].p);
                chk("sb_ones", ones, q[0].o);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_f", f, 0);
        chk("rst_zero", zero, 1);
        chk("rst_par", par, 0);
        chk("rst_ones", ones, 0);
        chk("rst_acc", acc, 0);
        chk("rst_count", count, 0);

        send(8'hB0, 8'hC0, 3'd0, 0, 0, 0); chk("and", f, 8'h80);
        send(8'hB0, 8'hC0, 3'd1, 0, 0, 0); chk("or", f, 8'hF0); chk("or_ready", tries, 1);
        send(8'hB0, 8'hC0, 3'd2, 0, 0, 0); chk("xor", f, 8'h70); chk("xor_ready", tries, 1);
        send(8'hB0, 8'hC0, 3'd3, 0, 0, 0); chk("not", f, 8'h4F);
        chk("stream_valid", out_valid, 1);
        chk("stream_count", count, 4);

        send(8'hFF, 8'hFF, 3'd4, 0, 0, 0); chk("nand", f, 8'h00); chk("nand_zero", zero, 1);
        send(8'hFF, 8'hFF, 3'd5, 0, 0, 0); chk("nor", f, 8'h00);
        send(8'hFF, 8'hFF, 3'd6, 0, 0, 0); chk("xnor", f, 8'hFF);
        chk("xnor_ones", ones, 1); chk("xnor_par", par, 0);

        send(8'h00, 8'h0F, 3'd7, 0, 1, 0); chk("chain1_acc", acc, 8'h0F);
        send(8'h00, 8'hFF, 3'd2, 1, 1, 0); chk("chain2_f", f, 8'hF0); chk("chain2_acc", acc, 8'hF0);
        send(8'h00, 8'h00, 3'd3, 1, 0, 0); chk("chain3_f", f, 8'h0F);

        c0 = count;
        out_ready = 0; bp = 2;
        send(8'h12, 8'hAA, 3'd7, 0, 0, 0);
        chk("bp_tries", tries, 4);
        chk("bp_count", count, (c0 + 1) % 256);
        chk("bp_f", f, 8'hAA);

        send(8'h00, 8'h55, 3'd7, 0, 1, 0); chk("clr_pre_acc", acc, 8'h55);
        send(8'h00, 8'h0A, 3'd1, 1, 1, 1); chk("clr_f", f, 8'h5F); chk("clr_acc", acc, 8'h00);

        send(8'h00, 8'h33, 3'd7, 0, 1, 0);
        do_reset();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_zero", zero, 1);
        chk("mid_rst_f", f, 0);

        repeat (5) send(8'h01, 8'h02, 3'd1, 0, 0, 0);
        chk("wrap_count2", count2, 1);
        chk("wrap_count8", count, 5);

        rnd = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 60 == 0) do_reset();
            send(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                 $urandom % 8 == 0);
            if ($urandom % 5 == 0) step();
        end
        rnd = 0;
        repeat (4) step();
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the 4-bit combinational logic unit.
- Performs one of eight bitwise operations on two WIDTH-bit operands and registers the result with status flags behind a valid/ready handshake.
- An internal accumulator can replace operand x, so a chain of logic operations can run without the operand coming back over the bus.
- Sits between the operand-fetch stage and the writeback stage of the lab datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 2)
- CNTW, 8, width of the transfer counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; synchronous and active-low
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept operand set
- x  in  WIDTH  operand x
- y  in  WIDTH  operand y
- op  in  3  operation select
- acc_sel  in  1  1: use accumulator in place of x
- acc_wr  in  1  1: load result into accumulator on transfer
- acc_clr  in  1  synchronous accumulator clear
- out_valid  out  1  result registered and pending
- out_ready  in  1  downstream accepts result
- f  out  WIDTH  result
- zero  out  1  f == 0
- par  out  1  XOR-reduction of f (odd parity)
- ones  out  1  f == all ones
- acc  out  WIDTH  accumulator value
- count  out  CNTW  number of accepted input transfers, wraps modulo 2^CNTW

## Operation
- Effective operand a = acc_sel ? acc : x.
- op encoding:
  - 000 AND a&y
  - 001 OR a|y
  - 010 XOR a^y
  - 011 NOT ~a
  - 100 NAND ~(a&y)
  - 101 NOR ~(a|y)
  - 110 XNOR ~(a^y)
  - 111 PASS y
- All results are exactly WIDTH bits; there is no carry and no sign.
- Input transfer occurs when in_valid && in_ready. On a transfer:
  - f, zero, par and ones load from the computed result.
  - out_valid ← 1.
  - count increments.
  - If acc_wr = 1, acc ← result.
- Output transfer occurs when out_valid && out_ready. If there is no simultaneous input transfer, out_valid ← 0. f and the flags hold their last value.
- in_ready = rst_n && (!out_valid || out_ready), combinational. This gives full-throughput streaming with a single output register.
- acc_clr is independent of the handshake. When asserted, acc ← 0 at the edge.
- Simultaneous acc_clr and a transfer with acc_wr: clear wins, acc ← 0. The transfer still computes using the pre-clear acc value.
- Inputs are ignored when in_ready = 0, including when in_valid is held high under backpressure. The producer must hold its operands stable.

## Timing
- Latency: 1 cycle. Operands accepted at edge N appear on f/out_valid after edge N.
- Accumulator chaining: the acc written at edge N is used as operand a for the input transferred at edge N+1. No bubble and no hazard.
- Backpressure: while out_valid && !out_ready:
  - in_ready = 0.
  - f, flags and count hold.
  - acc holds, except that acc_clr still applies.
- Reset (rst_n = 0 at a rising edge) sets out_valid = 0, f = 0, zero = 1, par = 0, ones = 0, acc = 0, count = 0.
- in_ready is 0 for as long as rst_n is low.
- Reset mid-stream drops any pending result with no output transfer, and discards a concurrent input.
- count wraps from 2^CNTW−1 to 0 with no flag.

## Structure
- Package lu_pkg holds:
  - op localparams OP_AND … OP_PASS, typedef lu_op_t (3-bit).
  - a typedef for the flag bundle {zero, par, ones}.
- Sub-module lu_core: purely combinational, parametrised by WIDTH; inputs (a, y, op), outputs (result, zero, par, ones).
- The top level holds:
  - the operand mux.
  - the handshake logic.
  - the output register.
  - the accumulator.
  - the counter.

## Test plan
All scenarios use WIDTH = 8.
- Reset, then with out_ready = 1 present x = 8'hB0, y = 8'hC0 and op = AND, OR, XOR, NOT on consecutive cycles. Required f on consecutive cycles: 8'h80, 8'hF0, 8'h70, 8'h4F, with out_valid held high and count = 4.
- NAND, then NOR, then XNOR, each with x = 8'hFF, y = 8'hFF. Required f: 8'h00 with zero = 1; then 8'h00; then 8'hFF with ones = 1 and par = 0.
- Accumulator chain:
  - Step 1: op = PASS, y = 8'h0F, acc_wr = 1. Required acc = 8'h0F.
  - Step 2: acc_sel = 1, op = XOR, y = 8'hFF, acc_wr = 1 on the next cycle. Required f = acc = 8'hF0.
  - Step 3: op = NOT on the following cycle. Required f = 8'h0F.
- Backpressure: out_ready = 0 for 3 cycles with in_valid high and new operands presented. Required: f holds, in_ready = 0, count is unchanged. Then raise out_ready: the held operand set is accepted one cycle later.
- acc_clr and a transfer with acc_wr = 1 in the same cycle, with acc = 8'h55 and op = OR, y = 8'h0A, acc_sel = 1. Required: f = 8'h5F and acc = 8'h00.
- Assert rst_n = 0 for 1 cycle while out_valid = 1. Required: out_valid = 0, acc = 0, count = 0, zero = 1. Also, with CNTW = 2, five transfers give count = 1.
